// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and sizing helper for the seven-segment number display.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        FORMAT
    } seg_state_t;

    // ceil(width * log10(2)), with log10(2) approximated as 0.30103
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/seg_num_display_seg7_encode.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_encode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_num_display.sv
// Signed integer to multi-digit seven-segment driver using a serial double-dabble engine.
// Define SEG_LZ_BLANK_EN to blank leading zeros and float the minus sign next to the value.
module seg_num_display
    import seg_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_WIDTH-1:0]     in_data,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    done,
    output logic                    ovf
);

    localparam int BCD_DIGITS = bcd_digits(IN_WIDTH);
    localparam int CW         = $clog2(IN_WIDTH);

    seg_state_t                      state;
    logic [IN_WIDTH-1:0]             din;
    logic [IN_WIDTH-1:0]             mag;
    logic                            neg;
    logic [CW-1:0]                   cnt;
    logic [BCD_DIGITS-1:0][3:0]      bcd;
    logic [BCD_DIGITS-1:0][3:0]      bcd_adj;
    logic [BCD_DIGITS-1:0][3:0]      bcd_nxt;
    logic [NUM_DIGITS-1:0][3:0]      disp_nib;
    logic [NUM_DIGITS-1:0][6:0]      seg_pat;
    logic [NUM_DIGITS-1:0][6:0]      fmt;
    logic [NUM_DIGITS-1:0]           keep;
    logic [NUM_DIGITS-1:0]           minus_at;
    logic                            ovf_c;

    // One double-dabble iteration: add-3 correction, then shift in the next magnitude bit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[i] >= 4'd5)
                bcd_adj[i] = bcd[i] + 4'd3;
        end
        bcd_nxt       = bcd_adj << 1;
        bcd_nxt[0][0] = mag[IN_WIDTH-1];
    end

    // A negative value needs one display digit for the sign.
    always_comb begin
        int lim;
        ovf_c = 1'b0;
        lim   = neg ? NUM_DIGITS - 1 : NUM_DIGITS;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (i >= lim && bcd[i] != 4'd0)
                ovf_c = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        if (g < BCD_DIGITS) begin : g_nib
            assign disp_nib[g] = bcd[g];
        end else begin : g_pad
            assign disp_nib[g] = 4'd0;
        end

        seg7_encode u_enc (
            .digit (disp_nib[g]),
            .seg   (seg_pat[g])
        );

`ifdef SEG_LZ_BLANK_EN
        if (g == 0) begin : g_lsd
            assign keep[g]     = 1'b1;
            assign minus_at[g] = 1'b0;
        end else begin : g_upper
            assign keep[g]     = |disp_nib[NUM_DIGITS-1:g];
            assign minus_at[g] = neg & ~keep[g] & keep[g-1];
        end
`else
        assign keep[g]     = 1'b1;
        assign minus_at[g] = (g == NUM_DIGITS - 1) ? neg : 1'b0;
`endif

        assign fmt[g] = (ovf_c || minus_at[g]) ? SEG_MINUS :
                        keep[g]                ? seg_pat[g] : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            done     <= 1'b0;
            ovf      <= 1'b0;
            hex      <= {NUM_DIGITS{SEG_BLANK}};
            din      <= '0;
            mag      <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        din      <= in_data;
                        in_ready <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // Two's-complement negate also yields 2^(W-1) correctly for the most negative value.
                    neg   <= din[IN_WIDTH-1];
                    mag   <= din[IN_WIDTH-1] ? -din : din;
                    bcd   <= '0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    bcd <= bcd_nxt;
                    mag <= mag << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(IN_WIDTH - 1))
                        state <= FORMAT;
                end
                FORMAT: begin
                    hex      <= fmt;
                    ovf      <= ovf_c;
                    done     <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_num_display.sv
// Directed and random bench for seg_num_display against a decimal-arithmetic reference model.
module tb_seg_num_display;

    localparam int W  = 32;
    localparam int ND = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [W-1:0]    in_data = '0;
    logic            in_ready;
    logic [7*ND-1:0] hex;
    logic            done;
    logic            ovf;

    int              nvec = 0;
    int              nerr = 0;
    logic [7*ND-1:0] prev_hex;
    logic [6:0]      pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    seg_num_display #(.IN_WIDTH(W), .NUM_DIGITS(ND)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .hex      (hex),
        .done     (done),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Display computed from the integer value with decimal arithmetic.
    function automatic logic [7*ND-1:0] model(input logic [W-1:0] v, output logic o);
        longint          s, m, lim, t;
        int              nd;
        logic            neg;
        logic [6:0]      p;
        logic [7*ND-1:0] r;
        s   = longint'($signed(v));
        neg = (s < 0);
        m   = neg ? -s : s;
        lim = 1;
        for (int i = 0; i < (neg ? ND - 1 : ND); i++) lim = lim * 10;
        o  = (m >= lim);
        nd = 1;
        t  = m;
        while (t >= 10) begin
            t = t / 10;
            nd++;
        end
        t = m;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            p = pats[int'(t % 10)];
            t = t / 10;
`ifdef SEG_LZ_BLANK_EN
            if (i >= nd) p = (neg && i == nd) ? 7'h3F : 7'h7F;
`else
            if (neg && i == ND - 1) p = 7'h3F;
`endif
            r[7*i +: 7] = o ? 7'h3F : p;
        end
        return r;
    endfunction

    task automatic convert(input logic [W-1:0] v, input bit poke);
        logic [7*ND-1:0] exp;
        logic            eo;
        int              cyc;
        int              w;
        exp = model(v, eo);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (poke && cyc == 10) begin
                chk("busy_ready", 64'(in_ready), 64'd0);
                in_valid = 1'b1;
                in_data  = 32'd5678;
            end
            if (poke && cyc == 14) in_valid = 1'b0;
            if (cyc == 20) chk("hex_hold", 64'(hex), 64'(prev_hex));
            if (done) break;
        end
        chk("latency", 64'(cyc), 64'(W + 2));
        chk("hex", 64'(hex), 64'(exp));
        chk("ovf", 64'(ovf), 64'(eo));
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("ready_after", 64'(in_ready), 64'd1);
        prev_hex = exp;
    endtask

    initial begin
        bit seen;
        logic [W-1:0] v;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_hex", 64'(hex), 64'({ND{7'h7F}}));
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        prev_hex = {ND{7'h7F}};

        convert(-32'sd42, 1'b0);
        convert(32'd0, 1'b0);
        convert(32'd9999, 1'b0);
        convert(-32'sd999, 1'b0);
        convert(32'd10000, 1'b0);
        convert(-32'sd1000, 1'b0);
        convert(32'h8000_0000, 1'b0);
        convert(32'd7, 1'b0);
        convert(32'd1234, 1'b1);

        // Reset in the middle of SHIFT must abort silently.
        in_valid = 1'b1;
        in_data  = 32'd1234;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_hex", 64'(hex), 64'({ND{7'h7F}}));
        chk("abort_ready", 64'(in_ready), 64'd1);
        chk("abort_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            seen |= done;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        prev_hex = {ND{7'h7F}};

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 2))
                0: v = $urandom;
                1: begin
                    v = W'($urandom_range(0, 12000));
                    if ($urandom_range(0, 1) == 1) v = -v;
                end
                default: v = -W'($urandom_range(0, 999));
            endcase
            convert(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
